// File: rtl/rob_interface.sv
// Registered ROB-to-RS dispatch FIFO with optional broadcast snoop of pending operands/flags.
// Build option: define ROB_IF_SNOOP_EN to fill waiting operands from the ROB broadcast bus.
module rob_interface #(
   parameter int DEPTH        = 2,
   parameter int GPR_SIZE     = 64,
   parameter int ROB_IDX_SIZE = 4,
   parameter int FU_OP_W      = 5
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_fu_id,
   input  logic [FU_OP_W-1:0]      in_fu_op,
   input  logic                    in_val_a_valid,
   input  logic                    in_val_b_valid,
   input  logic [GPR_SIZE-1:0]     in_val_a_value,
   input  logic [GPR_SIZE-1:0]     in_val_b_value,
   input  logic [ROB_IDX_SIZE-1:0] in_val_a_rob_index,
   input  logic [ROB_IDX_SIZE-1:0] in_val_b_rob_index,
   input  logic [ROB_IDX_SIZE-1:0] in_dst_rob_index,
   input  logic                    in_set_nzcv,
   input  logic                    in_uses_nzcv,
   input  logic                    in_nzcv_valid,
   input  logic [3:0]              in_nzcv,
   input  logic [ROB_IDX_SIZE-1:0] in_nzcv_rob_index,
   input  logic [3:0]              in_cond_codes,
   input  logic                    in_bc_done,
   input  logic [ROB_IDX_SIZE-1:0] in_bc_index,
   input  logic [GPR_SIZE-1:0]     in_bc_value,
   input  logic                    in_bc_set_nzcv,
   input  logic [3:0]              in_bc_nzcv,
   input  logic                    in_mispred,
   input  logic                    in_rs_ready,
   output logic                    out_valid,
   output logic                    out_fu_id,
   output logic [FU_OP_W-1:0]      out_fu_op,
   output logic                    out_val_a_valid,
   output logic                    out_val_b_valid,
   output logic [GPR_SIZE-1:0]     out_val_a_value,
   output logic [GPR_SIZE-1:0]     out_val_b_value,
   output logic [ROB_IDX_SIZE-1:0] out_val_a_rob_index,
   output logic [ROB_IDX_SIZE-1:0] out_val_b_rob_index,
   output logic [ROB_IDX_SIZE-1:0] out_dst_rob_index,
   output logic                    out_set_nzcv,
   output logic                    out_uses_nzcv,
   output logic                    out_nzcv_valid,
   output logic [3:0]              out_nzcv,
   output logic [ROB_IDX_SIZE-1:0] out_nzcv_rob_index,
   output logic [3:0]              out_cond_codes
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic                    fu_id;
      logic [FU_OP_W-1:0]      fu_op;
      logic                    val_a_valid;
      logic [GPR_SIZE-1:0]     val_a_value;
      logic [ROB_IDX_SIZE-1:0] val_a_rob_index;
      logic                    val_b_valid;
      logic [GPR_SIZE-1:0]     val_b_value;
      logic [ROB_IDX_SIZE-1:0] val_b_rob_index;
      logic [ROB_IDX_SIZE-1:0] dst_rob_index;
      logic                    set_nzcv;
      logic                    uses_nzcv;
      logic                    nzcv_valid;
      logic [3:0]              nzcv;
      logic [ROB_IDX_SIZE-1:0] nzcv_rob_index;
      logic [3:0]              cond_codes;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          in_entry;
   entry_t          head_entry;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic            do_enq;
   logic            do_deq;

   // Handshake: a transfer happens on a posedge where valid and ready are both high;
   // ready depends only on registered state, so it never looks at the other side's valid.
   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign do_enq    = in_valid & in_ready;
   assign do_deq    = out_valid & in_rs_ready;

   assign in_entry = '{
      fu_id:           in_fu_id,
      fu_op:           in_fu_op,
      val_a_valid:     in_val_a_valid,
      val_a_value:     in_val_a_value,
      val_a_rob_index: in_val_a_rob_index,
      val_b_valid:     in_val_b_valid,
      val_b_value:     in_val_b_value,
      val_b_rob_index: in_val_b_rob_index,
      dst_rob_index:   in_dst_rob_index,
      set_nzcv:        in_set_nzcv,
      uses_nzcv:       in_uses_nzcv,
      nzcv_valid:      in_nzcv_valid,
      nzcv:            in_nzcv,
      nzcv_rob_index:  in_nzcv_rob_index,
      cond_codes:      in_cond_codes
   };

`ifdef ROB_IF_SNOOP_EN
   // Only fields still waiting on a tag are filled; resolved ones are left alone.
   function automatic entry_t snoop(input entry_t e);
      entry_t r;
      r = e;
      if (in_bc_done) begin
         if (!e.val_a_valid && e.val_a_rob_index == in_bc_index) begin
            r.val_a_value = in_bc_value;
            r.val_a_valid = 1'b1;
         end
         if (!e.val_b_valid && e.val_b_rob_index == in_bc_index) begin
            r.val_b_value = in_bc_value;
            r.val_b_valid = 1'b1;
         end
         if (in_bc_set_nzcv && e.uses_nzcv && !e.nzcv_valid &&
             e.nzcv_rob_index == in_bc_index) begin
            r.nzcv       = in_bc_nzcv;
            r.nzcv_valid = 1'b1;
         end
      end
      return r;
   endfunction
`else
   logic unused_bc;
   assign unused_bc = ^{in_bc_done, in_bc_index, in_bc_value, in_bc_set_nzcv, in_bc_nzcv};

   function automatic entry_t snoop(input entry_t e);
      return e;
   endfunction
`endif

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (in_mispred) begin
         // Flush wins over any transfer offered in the same cycle.
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= snoop(mem[i]);
         if (do_enq) begin
            mem[tail] <= snoop(in_entry);
            tail      <= tail + PW'(1);
         end
         if (do_deq) head <= head + PW'(1);
         case ({do_enq, do_deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_entry          = mem[head];
   assign out_fu_id           = head_entry.fu_id;
   assign out_fu_op           = head_entry.fu_op;
   assign out_val_a_valid     = head_entry.val_a_valid;
   assign out_val_b_valid     = head_entry.val_b_valid;
   assign out_val_a_value     = head_entry.val_a_value;
   assign out_val_b_value     = head_entry.val_b_value;
   assign out_val_a_rob_index = head_entry.val_a_rob_index;
   assign out_val_b_rob_index = head_entry.val_b_rob_index;
   assign out_dst_rob_index   = head_entry.dst_rob_index;
   assign out_set_nzcv        = head_entry.set_nzcv;
   assign out_uses_nzcv       = head_entry.uses_nzcv;
   assign out_nzcv_valid      = head_entry.nzcv_valid;
   assign out_nzcv            = head_entry.nzcv;
   assign out_nzcv_rob_index  = head_entry.nzcv_rob_index;
   assign out_cond_codes      = head_entry.cond_codes;

endmodule

// File: tb/tb_rob_interface.sv
// Bench for rob_interface: directed cases plus random traffic checked against a queue-based model.
module tb_rob_interface;

   localparam int DEPTH = 2;
`ifdef ROB_IF_SNOOP_EN
   localparam bit SNOOP_ON = 1'b1;
`else
   localparam bit SNOOP_ON = 1'b0;
`endif

   typedef struct packed {
      logic        fu_id;
      logic [4:0]  fu_op;
      logic        a_valid;
      logic [63:0] a_value;
      logic [3:0]  a_idx;
      logic        b_valid;
      logic [63:0] b_value;
      logic [3:0]  b_idx;
      logic [3:0]  dst;
      logic        set_nzcv;
      logic        uses_nzcv;
      logic        nzcv_valid;
      logic [3:0]  nzcv;
      logic [3:0]  nzcv_idx;
      logic [3:0]  cond;
   } ent_t;
   localparam int W = $bits(ent_t);

   logic        in_clk = 1'b0;
   logic        in_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_fu_id = 1'b0;
   logic [4:0]  in_fu_op = '0;
   logic        in_val_a_valid = 1'b0, in_val_b_valid = 1'b0;
   logic [63:0] in_val_a_value = '0, in_val_b_value = '0;
   logic [3:0]  in_val_a_rob_index = '0, in_val_b_rob_index = '0;
   logic [3:0]  in_dst_rob_index = '0;
   logic        in_set_nzcv = 1'b0, in_uses_nzcv = 1'b0, in_nzcv_valid = 1'b0;
   logic [3:0]  in_nzcv = '0, in_nzcv_rob_index = '0, in_cond_codes = '0;
   logic        in_bc_done = 1'b0;
   logic [3:0]  in_bc_index = '0;
   logic [63:0] in_bc_value = '0;
   logic        in_bc_set_nzcv = 1'b0;
   logic [3:0]  in_bc_nzcv = '0;
   logic        in_mispred = 1'b0;
   logic        in_rs_ready = 1'b0;
   logic        out_valid;
   logic        out_fu_id;
   logic [4:0]  out_fu_op;
   logic        out_val_a_valid, out_val_b_valid;
   logic [63:0] out_val_a_value, out_val_b_value;
   logic [3:0]  out_val_a_rob_index, out_val_b_rob_index, out_dst_rob_index;
   logic        out_set_nzcv, out_uses_nzcv, out_nzcv_valid;
   logic [3:0]  out_nzcv, out_nzcv_rob_index, out_cond_codes;

   rob_interface #(.DEPTH(DEPTH), .GPR_SIZE(64), .ROB_IDX_SIZE(4), .FU_OP_W(5)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fu_id(in_fu_id), .in_fu_op(in_fu_op),
      .in_val_a_valid(in_val_a_valid), .in_val_b_valid(in_val_b_valid),
      .in_val_a_value(in_val_a_value), .in_val_b_value(in_val_b_value),
      .in_val_a_rob_index(in_val_a_rob_index), .in_val_b_rob_index(in_val_b_rob_index),
      .in_dst_rob_index(in_dst_rob_index), .in_set_nzcv(in_set_nzcv),
      .in_uses_nzcv(in_uses_nzcv), .in_nzcv_valid(in_nzcv_valid), .in_nzcv(in_nzcv),
      .in_nzcv_rob_index(in_nzcv_rob_index), .in_cond_codes(in_cond_codes),
      .in_bc_done(in_bc_done), .in_bc_index(in_bc_index), .in_bc_value(in_bc_value),
      .in_bc_set_nzcv(in_bc_set_nzcv), .in_bc_nzcv(in_bc_nzcv),
      .in_mispred(in_mispred), .in_rs_ready(in_rs_ready), .out_valid(out_valid),
      .out_fu_id(out_fu_id), .out_fu_op(out_fu_op),
      .out_val_a_valid(out_val_a_valid), .out_val_b_valid(out_val_b_valid),
      .out_val_a_value(out_val_a_value), .out_val_b_value(out_val_b_value),
      .out_val_a_rob_index(out_val_a_rob_index), .out_val_b_rob_index(out_val_b_rob_index),
      .out_dst_rob_index(out_dst_rob_index), .out_set_nzcv(out_set_nzcv),
      .out_uses_nzcv(out_uses_nzcv), .out_nzcv_valid(out_nzcv_valid), .out_nzcv(out_nzcv),
      .out_nzcv_rob_index(out_nzcv_rob_index), .out_cond_codes(out_cond_codes)
   );

   // ---------------- clock / reset ----------------
   always #5 in_clk = ~in_clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];
   ent_t         model_q[$];

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic ent_t dut_out();
      return {out_fu_id, out_fu_op, out_val_a_valid, out_val_a_value, out_val_a_rob_index,
              out_val_b_valid, out_val_b_value, out_val_b_rob_index, out_dst_rob_index,
              out_set_nzcv, out_uses_nzcv, out_nzcv_valid, out_nzcv, out_nzcv_rob_index,
              out_cond_codes};
   endfunction

   function automatic ent_t cur_in();
      return {in_fu_id, in_fu_op, in_val_a_valid, in_val_a_value, in_val_a_rob_index,
              in_val_b_valid, in_val_b_value, in_val_b_rob_index, in_dst_rob_index,
              in_set_nzcv, in_uses_nzcv, in_nzcv_valid, in_nzcv, in_nzcv_rob_index,
              in_cond_codes};
   endfunction

   // Broadcast rule: fill anything still waiting on the broadcast tag.
   function automatic ent_t snoop(input ent_t e);
      if (SNOOP_ON && in_bc_done) begin
         if (!e.a_valid && e.a_idx == in_bc_index) begin e.a_value = in_bc_value; e.a_valid = 1'b1; end
         if (!e.b_valid && e.b_idx == in_bc_index) begin e.b_value = in_bc_value; e.b_valid = 1'b1; end
         if (in_bc_set_nzcv && e.uses_nzcv && !e.nzcv_valid && e.nzcv_idx == in_bc_index) begin
            e.nzcv = in_bc_nzcv; e.nzcv_valid = 1'b1;
         end
      end
      return e;
   endfunction

   // ---------------- reference model ----------------
   initial begin
      forever begin
         @(posedge in_clk or negedge in_rst);
         if (!in_rst) model_q.delete();
         else if (in_mispred) model_q.delete();
         else begin
            int  n;
            bit  rdy;
            n   = model_q.size();
            rdy = (n < DEPTH);
            if (n != 0 && in_rs_ready) exp_q.push_back(model_q.pop_front());
            foreach (model_q[i]) model_q[i] = snoop(model_q[i]);
            if (in_valid && rdy) model_q.push_back(snoop(cur_in()));
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge in_clk);
         chk("out_valid", out_valid, model_q.size() != 0);
         chk("in_ready", in_ready, model_q.size() < DEPTH);
         if (out_valid === 1'b1 && model_q.size() != 0) chk("head_payload", dut_out(), model_q[0]);
         if (out_valid === 1'b1 && in_rs_ready && !in_mispred && in_rst) begin
            logic [W-1:0] got;
            got = dut_out();
            @(posedge in_clk);
            #1;
            if (exp_q.size() == 0) chk("deq_unexpected", 1'b1, 1'b0);
            else chk("deq_payload", got, exp_q.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic cycle();
      @(posedge in_clk);
      #2;
   endtask

   task automatic drive(input ent_t e);
      {in_fu_id, in_fu_op, in_val_a_valid, in_val_a_value, in_val_a_rob_index,
       in_val_b_valid, in_val_b_value, in_val_b_rob_index, in_dst_rob_index,
       in_set_nzcv, in_uses_nzcv, in_nzcv_valid, in_nzcv, in_nzcv_rob_index,
       in_cond_codes} = e;
   endtask

   task automatic enqueue(input ent_t e);
      drive(e);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic broadcast(input logic [3:0] idx, input logic [63:0] val,
                            input logic set_f, input logic [3:0] f);
      in_bc_done = 1'b1; in_bc_index = idx; in_bc_value = val;
      in_bc_set_nzcv = set_f; in_bc_nzcv = f;
      cycle();
      in_bc_done = 1'b0; in_bc_set_nzcv = 1'b0;
   endtask

   task automatic dequeue_one();
      in_rs_ready = 1'b1;
      cycle();
      in_rs_ready = 1'b0;
   endtask

   function automatic ent_t base_entry(input logic [3:0] dst);
      ent_t e;
      e = '0;
      e.fu_op = 5'd1; e.a_valid = 1'b1; e.a_value = 64'h11; e.a_idx = 4'd13;
      e.b_valid = 1'b1; e.b_value = 64'h22; e.b_idx = 4'd14; e.dst = dst;
      e.nzcv_valid = 1'b1; e.nzcv_idx = 4'd15; e.cond = 4'ha;
      return e;
   endfunction

   function automatic ent_t rand_entry();
      ent_t e;
      e.fu_id = 1'($urandom_range(0, 1)); e.fu_op = 5'($urandom);
      e.a_valid = 1'($urandom_range(0, 1)); e.a_value = {$urandom, $urandom};
      e.a_idx = 4'($urandom_range(0, 7));
      e.b_valid = 1'($urandom_range(0, 1)); e.b_value = {$urandom, $urandom};
      e.b_idx = 4'($urandom_range(0, 7)); e.dst = 4'($urandom);
      e.set_nzcv = 1'($urandom_range(0, 1)); e.uses_nzcv = 1'($urandom_range(0, 1));
      e.nzcv_valid = 1'($urandom_range(0, 1)); e.nzcv = 4'($urandom);
      e.nzcv_idx = 4'($urandom_range(0, 7)); e.cond = 4'($urandom);
      return e;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      ent_t e;
      repeat (3) @(posedge in_clk);
      #3 in_rst = 1'b1;
      cycle();
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_payload", dut_out(), '0);

      // single entry, one-cycle latency
      e = base_entry(4'd2); e.a_value = 64'd5; e.fu_op = 5'd3;
      enqueue(e);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_a_value", out_val_a_value, 64'd5);
      chk("t1_dst", out_dst_rob_index, 4'd2);
      dequeue_one();
      chk("t1_empty", out_valid, 1'b0);

      // fill, then drain in order across the pointer wrap
      enqueue(base_entry(4'd1));
      enqueue(base_entry(4'd2));
      chk("t2_full", in_ready, 1'b0);
      chk("t2_head1", out_dst_rob_index, 4'd1);
      in_rs_ready = 1'b1;
      cycle();
      chk("t2_head2", out_dst_rob_index, 4'd2);
      cycle();
      in_rs_ready = 1'b0;
      chk("t2_empty", out_valid, 1'b0);

      // operand snoop
      e = base_entry(4'd4); e.b_valid = 1'b0; e.b_idx = 4'd7; e.b_value = 64'd0;
      enqueue(e);
      broadcast(4'd6, 64'h1234, 1'b0, 4'h0);
      chk("t3_miss_valid", out_val_b_valid, 1'b0);
      chk("t3_miss_value", out_val_b_value, 64'd0);
      broadcast(4'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'h0);
      chk("t3_hit_valid", out_val_b_valid, SNOOP_ON);
      chk("t3_hit_value", out_val_b_value, SNOOP_ON ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0);
      chk("t3_a_kept", out_val_a_value, 64'h11);
      dequeue_one();

      // flag snoop
      e = base_entry(4'd5); e.uses_nzcv = 1'b1; e.nzcv_valid = 1'b0; e.nzcv_idx = 4'd3; e.nzcv = 4'h0;
      enqueue(e);
      broadcast(4'd3, 64'h0, 1'b0, 4'b0100);
      chk("t4_noset_valid", out_nzcv_valid, 1'b0);
      broadcast(4'd3, 64'h0, 1'b1, 4'b0100);
      chk("t4_set_valid", out_nzcv_valid, SNOOP_ON);
      chk("t4_set_nzcv", out_nzcv, SNOOP_ON ? 4'b0100 : 4'b0000);
      dequeue_one();

      // mispredict beats a simultaneous enqueue
      enqueue(base_entry(4'd5));
      enqueue(base_entry(4'd6));
      drive(base_entry(4'd7));
      in_valid = 1'b1; in_mispred = 1'b1;
      cycle();
      in_valid = 1'b0; in_mispred = 1'b0;
      chk("t5_flushed", out_valid, 1'b0);
      chk("t5_ready", in_ready, 1'b1);
      cycle();
      chk("t5_dropped", out_valid, 1'b0);

      // asynchronous reset in the middle of a cycle
      enqueue(base_entry(4'd8));
      #1 in_rst = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_payload", dut_out(), '0);
      @(posedge in_clk);
      #3 in_rst = 1'b1;
      cycle();
      enqueue(base_entry(4'd9));
      chk("t6_resume_valid", out_valid, 1'b1);
      chk("t6_resume_dst", out_dst_rob_index, 4'd9);
      dequeue_one();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         drive(rand_entry());
         in_valid       = ($urandom_range(0, 99) < 60);
         in_rs_ready    = ($urandom_range(0, 99) < 50);
         in_bc_done     = ($urandom_range(0, 99) < 50);
         in_bc_index    = 4'($urandom_range(0, 7));
         in_bc_value    = {$urandom, $urandom};
         in_bc_set_nzcv = 1'($urandom_range(0, 1));
         in_bc_nzcv     = 4'($urandom);
         in_mispred     = ($urandom_range(0, 39) == 0);
         cycle();
      end
      in_valid = 1'b0; in_bc_done = 1'b0; in_mispred = 1'b0; in_rs_ready = 1'b1;
      repeat (DEPTH + 3) cycle();
      chk("drain_exp_q", exp_q.size(), 0);
      chk("drain_model", model_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
